// File: rtl/pattern_merge_pipe.sv
// Elastic pattern pipeline: per-lane AND/NOR patterns, DEPTH valid/ready register
// stages, and a saturating count of output words with any pattern bit set.
module pattern_merge_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_q,
  output logic             out_any,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_count
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] accept;
  logic [WIDTH-1:0] p_q [DEPTH];
  logic [WIDTH-1:0] p_d [DEPTH];
  logic [WIDTH-1:0] q_q [DEPTH];
  logic [WIDTH-1:0] q_d [DEPTH];
  logic [WIDTH-1:0] in_p, in_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_tail;
  logic             out_xfer;

  always_comb begin
    in_p = in_a & in_b & ~in_c;
    in_q = ~(in_a | in_b) & ~in_c;
  end

  // A stage can take a word when any stage from it to the tail has a bubble,
  // or the tail drains; computed as a suffix-AND instead of a stage-to-stage chain.
  always_comb begin
    accept    = '0;
    full_tail = 1'b1;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      full_tail             = full_tail & vld_q[DEPTH-1-j];
      accept[DEPTH-1-j]     = out_ready | ~full_tail;
    end
  end

  always_comb begin
    vld_d = vld_q;
    p_d   = p_q;
    q_d   = q_q;
    if (accept[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        p_d[0] = in_p;
        q_d[0] = in_q;
      end
    end
    for (int unsigned j = 1; j < DEPTH; j++) begin
      if (accept[j]) begin
        vld_d[j] = vld_q[j-1];
        if (vld_q[j-1]) begin
          p_d[j] = p_q[j-1];
          q_d[j] = q_q[j-1];
        end
      end
    end
  end

  always_comb begin
    in_ready  = accept[0];
    out_valid = vld_q[DEPTH-1];
    out_p     = p_q[DEPTH-1];
    out_q     = q_q[DEPTH-1];
    out_any   = vld_q[DEPTH-1] & (|(p_q[DEPTH-1] | q_q[DEPTH-1]));
    out_xfer  = vld_q[DEPTH-1] & out_ready;
    hit_count = cnt_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer && out_any && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        p_q[j] <= '0;
        q_q[j] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        p_q[j] <= p_d[j];
        q_q[j] <= q_d[j];
      end
    end
  end

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Scoreboard bench for pattern_merge_pipe: three instances (DEPTH 2/1/3, one with a
// 2-bit counter), directed checks plus randomized valid/ready traffic.
module tb_pattern_merge_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       iv [3];
  logic       ordy [3];
  logic       clr [3];
  logic       ir [3];
  logic       ov [3];
  logic       oany [3];
  logic [3:0] ia [3];
  logic [3:0] ib [3];
  logic [3:0] ic [3];
  logic [3:0] op [3];
  logic [3:0] oq [3];
  logic [7:0] hc0, hc2;
  logic [1:0] hc1;
  int         hc [3];

  always_comb begin
    hc[0] = int'(hc0);
    hc[1] = int'(hc1);
    hc[2] = int'(hc2);
  end

  pattern_merge_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) u_d2 (
    .blif_clk_net(clk), .blif_reset_net(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]), .in_c(ic[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(op[0]), .out_q(oq[0]),
    .out_any(oany[0]), .cnt_clr(clr[0]), .hit_count(hc0));

  pattern_merge_pipe #(.WIDTH(4), .DEPTH(1), .CNT_W(2)) u_d1 (
    .blif_clk_net(clk), .blif_reset_net(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1]), .in_b(ib[1]), .in_c(ic[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(op[1]), .out_q(oq[1]),
    .out_any(oany[1]), .cnt_clr(clr[1]), .hit_count(hc1));

  pattern_merge_pipe #(.WIDTH(4), .DEPTH(3), .CNT_W(8)) u_d3 (
    .blif_clk_net(clk), .blif_reset_net(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]), .in_c(ic[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(op[2]), .out_q(oq[2]),
    .out_any(oany[2]), .cnt_clr(clr[2]), .hit_count(hc2));

  // Reference: lane-by-lane truth of the two patterns, packed as {p, q}.
  function automatic logic [7:0] ref_word(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c);
    logic [3:0] p, q;
    p = '0;
    q = '0;
    for (int l = 0; l < 4; l++) begin
      if (!c[l] && a[l] && b[l])   p[l] = 1'b1;
      if (!c[l] && !a[l] && !b[l]) q[l] = 1'b1;
    end
    return {p, q};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  logic [7:0] sb [3][$];
  int         cnt_m [3];
  int         maxc [3] = '{255, 3, 255};
  logic       hold [3];
  logic [7:0] held [3];
  int         popped [3] = '{0, 0, 0};
  logic [7:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sb[i].delete();
        cnt_m[i] = 0;
        hold[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hit_count[%0d]", i), hc[i], cnt_m[i]);
        check($sformatf("out_any[%0d]", i), int'(oany[i]),
              int'(ov[i] && (op[i] != 4'd0 || oq[i] != 4'd0)));
        if (hold[i]) begin
          check($sformatf("hold_valid[%0d]", i), int'(ov[i]), 1);
          check($sformatf("hold_data[%0d]", i), int'({op[i], oq[i]}), int'(held[i]));
        end
        hold[i] = ov[i] && !ordy[i];
        held[i] = {op[i], oq[i]};
        if (ov[i] && ordy[i]) begin
          if (sb[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_out[%0d]: got word 0x%0h, expected no output at %0t",
                     i, {op[i], oq[i]}, $time);
          end else begin
            mon_e = sb[i].pop_front();
            check($sformatf("word[%0d]", i), int'({op[i], oq[i]}), int'(mon_e));
            popped[i]++;
            if (!clr[i] && mon_e != 8'd0 && cnt_m[i] < maxc[i]) cnt_m[i]++;
          end
        end
        if (clr[i]) cnt_m[i] = 0;
        if (iv[i] && ir[i]) sb[i].push_back(ref_word(ia[i], ib[i], ic[i]));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int i);
    for (int n = 0; n < 200; n++) begin
      if (sb[i].size() == 0 && !ov[i]) break;
      @(negedge clk);
    end
    check($sformatf("drain_pending[%0d]", i), sb[i].size(), 0);
  endtask

  int         exp38 [7] = '{0, 0, 1, 2, 3, 3, 3};
  logic [7:0] w035;
  int         h037;
  int         cyc;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; clr[i] = 1'b0;
      ia[i] = '0; ib[i] = '0; ic[i] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid[%0d]", i), int'(ov[i]), 0);
      check($sformatf("rst_in_ready[%0d]", i), int'(ir[i]), 1);
      check($sformatf("rst_out_pq[%0d]", i), int'({op[i], oq[i]}), 0);
      check($sformatf("rst_out_any[%0d]", i), int'(oany[i]), 0);
      check($sformatf("rst_hit[%0d]", i), hc[i], 0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single word, DEPTH=2: visible two cycles after being presented.
    next_cycle();
    ia[0] = 4'b1010; ib[0] = 4'b1001; ic[0] = 4'b0100; iv[0] = 1'b1;
    w035 = ref_word(4'b1010, 4'b1001, 4'b0100);
    @(negedge clk);
    check("d035_in_ready", int'(ir[0]), 1);
    next_cycle();
    iv[0] = 1'b0;
    @(negedge clk);
    check("d035_valid_early", int'(ov[0]), 0);
    next_cycle();
    @(negedge clk);
    check("d035_valid", int'(ov[0]), 1);
    check("d035_p", int'(op[0]), 8);
    check("d035_q", int'(oq[0]), int'(w035[3:0]));
    check("d035_any", int'(oany[0]), 1);
    next_cycle();
    @(negedge clk);
    check("d035_valid_after", int'(ov[0]), 0);
    check("d035_hit", hc[0], 1);

    // Backpressure: two words fill the pipe, third waits for out_ready.
    ordy[0] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      iv[0] = 1'b1;
      ia[0] = 4'($urandom); ib[0] = 4'($urandom); ic[0] = 4'($urandom);
      @(negedge clk);
      check($sformatf("d036_ready_w%0d", w), int'(ir[0]), (w < 2) ? 1 : 0);
    end
    next_cycle();
    @(negedge clk);
    check("d036_ready_stall", int'(ir[0]), 0);
    next_cycle();
    ordy[0] = 1'b1;
    @(negedge clk);
    check("d036_ready_release", int'(ir[0]), 1);
    next_cycle();
    iv[0] = 1'b0;
    drain(0);

    // in_c all ones blocks both patterns: no hits.
    h037 = hc[0];
    for (int w = 0; w < 5; w++) begin
      next_cycle();
      iv[0] = 1'b1;
      ia[0] = 4'($urandom); ib[0] = 4'($urandom); ic[0] = 4'b1111;
    end
    next_cycle();
    iv[0] = 1'b0;
    drain(0);
    check("d037_hit_unchanged", hc[0], h037);

    // 2-bit counter saturation, then clear beating a same-cycle hit.
    next_cycle();
    clr[1] = 1'b1;
    next_cycle();
    clr[1] = 1'b0;
    @(negedge clk);
    check("d038_cleared", hc[1], 0);
    for (int k = 0; k < 7; k++) begin
      next_cycle();
      iv[1] = (k < 5);
      ia[1] = 4'b1111; ib[1] = 4'b1111; ic[1] = 4'b0000;
      @(negedge clk);
      check($sformatf("d038_hit_seq%0d", k), hc[1], exp38[k]);
    end
    next_cycle();
    iv[1] = 1'b1;
    next_cycle();
    iv[1] = 1'b0;
    clr[1] = 1'b1;
    @(negedge clk);
    check("d038_clr_xfer_valid", int'(ov[1]), 1);
    next_cycle();
    clr[1] = 1'b0;
    @(negedge clk);
    check("d038_clr_priority", hc[1], 0);

    // Full pipe, asynchronous reset pulse: everything in flight is discarded.
    ordy[0] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      iv[0] = 1'b1;
      ia[0] = 4'b1111; ib[0] = 4'b1111; ic[0] = 4'b0000;
    end
    next_cycle();
    iv[0] = 1'b0;
    @(negedge clk);
    check("d039_full_valid", int'(ov[0]), 1);
    check("d039_full_ready", int'(ir[0]), 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("d039_valid_drop", int'(ov[0]), 0);
    check("d039_ready", int'(ir[0]), 1);
    check("d039_hit", hc[0], 0);
    check("d039_pq", int'({op[0], oq[0]}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ordy[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("d039_no_old_word", int'(ov[0]), 0);
    end

    // Random traffic on all instances.
    cyc = 0;
    while ((popped[1] < 10000 || popped[2] < 10000 || popped[0] < 10000) && cyc < 40000) begin
      next_cycle();
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom % 4) != 0;
        ordy[i] = ($urandom % 4) != 0;
        clr[i]  = ($urandom % 64) == 0;
        ia[i]   = 4'($urandom);
        ib[i]   = 4'($urandom);
        ic[i]   = 4'($urandom);
      end
      cyc++;
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; clr[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) drain(i);
    for (int i = 0; i < 3; i++)
      check($sformatf("rand_enough_words[%0d]", i), int'(popped[i] >= 10000), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
